matmul_sequencer: RTL and testbench

Multi-cycle controller that executes the 2x2 matrix-multiply instruction. It is triggered by the `is_matrix_mult` flag leaving the MEM/WB stage. It sequences reads of the register file, runs a single multiply-accumulate datapath and writes the four 8-bit results to data memory. While it owns the register-file read ports and the data-memory write port, it holds the pipeline with `stall`.

---
 rtl/matmul_sequencer.sv | 107 ++++++++++
 tb/tb_matmul_sequencer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/matmul_sequencer.sv
// Multi-cycle sequencer for the 2x2 matrix-multiply instruction: reads A/B from the
// register file, runs one MAC datapath, writes C to data memory. Optional build macro: MATMUL_SAT_EN.
module matmul_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] base_addr,
  output logic [2:0] rd_addr1,
  output logic [2:0] rd_addr2,
  input  logic [7:0] rd_data1,
  input  logic [7:0] rd_data2,
  output logic       mem_we,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       stall,
  output logic       done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MUL0  = 3'd1,
    MUL1  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t      state, state_nxt;
  logic [1:0]  n;      // element index, n = 2i + j
  logic [7:0]  base;
  logic [16:0] acc;
  logic [15:0] prod;
  logic [7:0]  result;

  assign prod = 16'(rd_data1) * 16'(rd_data2);

`ifdef MATMUL_SAT_EN
  assign result = (acc > 17'd255) ? 8'hFF : acc[7:0];
`else
  assign result = acc[7:0];
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      n     <= 2'd0;
      base  <= 8'd0;
      acc   <= 17'd0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (start) begin
          n    <= 2'd0;
          base <= base_addr;
          acc  <= 17'd0;
        end
        MUL0:  acc <= {1'b0, prod};
        MUL1:  acc <= acc + {1'b0, prod};
        WRITE: if (n != 2'd3) n <= n + 2'd1;
        default: ;
      endcase
    end
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    rd_addr1  = 3'd0;
    rd_addr2  = 3'd0;
    mem_we    = 1'b0;
    mem_addr  = 8'd0;
    mem_wdata = 8'd0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) begin
        stall     = 1'b1;
        state_nxt = MUL0;
      end
      MUL0: begin
        stall     = 1'b1;
        rd_addr1  = {1'b0, n[1], 1'b0};   // a_i0
        rd_addr2  = {2'b10, n[0]};        // b_0j
        state_nxt = MUL1;
      end
      MUL1: begin
        stall     = 1'b1;
        rd_addr1  = {1'b0, n[1], 1'b1};   // a_i1
        rd_addr2  = {2'b11, n[0]};        // b_1j
        state_nxt = WRITE;
      end
      WRITE: begin
        stall     = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = base + {6'd0, n};
        mem_wdata = result;
        state_nxt = (n == 2'd3) ? DONE : MUL0;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_matmul_sequencer.sv
// Self-checking bench for matmul_sequencer: per-cycle output checks against a
// cycle-indexed reference built from the matrix product and the documented timeline.
module tb_matmul_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] base_addr;
  logic [2:0] rd_addr1, rd_addr2;
  logic [7:0] rd_data1, rd_data2;
  logic       mem_we;
  logic [7:0] mem_addr, mem_wdata;
  logic       stall, done;

  logic [7:0] regs [8];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign rd_data1 = regs[rd_addr1];
  assign rd_data2 = regs[rd_addr2];

  matmul_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .rd_addr1  (rd_addr1),
    .rd_addr2  (rd_addr2),
    .rd_data1  (rd_data1),
    .rd_data2  (rd_data2),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .stall     (stall),
    .done      (done)
  );

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  // c_ij = sum_k a_ik * b_kj with a_ik = r(2i+k), b_kj = r(4+2k+j)
  function automatic logic [7:0] ref_c(input int n);
    int i, j, s;
    i = n / 2;
    j = n % 2;
    s = 0;
    for (int k = 0; k < 2; k++) s += int'(regs[2*i+k]) * int'(regs[4+2*k+j]);
`ifdef MATMUL_SAT_EN
    return (s > 255) ? 8'hFF : 8'(s);
`else
    return 8'(s);
`endif
  endfunction

  task automatic check_all_zero(input string tag, input int k);
    chk({tag, "_stall"}, k, 32'(stall), 0);
    chk({tag, "_done"},  k, 32'(done), 0);
    chk({tag, "_we"},    k, 32'(mem_we), 0);
    chk({tag, "_addr"},  k, 32'(mem_addr), 0);
    chk({tag, "_wdata"}, k, 32'(mem_wdata), 0);
    chk({tag, "_rd1"},   k, 32'(rd_addr1), 0);
    chk({tag, "_rd2"},   k, 32'(rd_addr2), 0);
  endtask

  // Runs one operation from its start cycle T (k=0) to DONE (k=13); ends at the
  // first cycle after DONE so a caller can start again back-to-back.
  task automatic run_op(input logic [7:0] base, input int rst_at, input bit busy_starts);
    logic [7:0] exp_c [4];
    for (int n = 0; n < 4; n++) exp_c[n] = ref_c(n);
    for (int k = 0; k < 14; k++) begin
      bit after_rst, exp_we, exp_stall, exp_done;
      int e, ph, en;
      logic [7:0] exp_addr, exp_wdata;
      logic [2:0] exp_rd1, exp_rd2;
      after_rst = (rst_at >= 0) && (k > rst_at);
      start     = (k == 0) || (busy_starts && (k == 5 || k == 13));
      base_addr = (k == 0) ? base : 8'h40;
      reset     = (k == rst_at);
      exp_stall = !after_rst && (k <= 12);
      exp_done  = !after_rst && (k == 13);
      exp_we    = !after_rst && (k >= 3) && (k <= 12) && (k % 3 == 0);
      en        = k / 3 - 1;
      exp_addr  = exp_we ? base + 8'(en) : 8'd0;
      exp_wdata = exp_we ? exp_c[en] : 8'd0;
      exp_rd1   = 3'd0;
      exp_rd2   = 3'd0;
      if (!after_rst && k >= 1 && k <= 12) begin
        e  = (k - 1) / 3;
        ph = (k - 1) % 3;
        if (ph < 2) begin
          exp_rd1 = 3'(2 * (e / 2) + ph);
          exp_rd2 = 3'(4 + 2 * ph + (e % 2));
        end
      end
      @(negedge clk);
      chk("stall", k, 32'(stall), 32'(exp_stall));
      chk("done",  k, 32'(done), 32'(exp_done));
      chk("we",    k, 32'(mem_we), 32'(exp_we));
      chk("addr",  k, 32'(mem_addr), 32'(exp_addr));
      chk("wdata", k, 32'(mem_wdata), 32'(exp_wdata));
      chk("rd1",   k, 32'(rd_addr1), 32'(exp_rd1));
      chk("rd2",   k, 32'(rd_addr2), 32'(exp_rd2));
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    reset = 1'b0;
  endtask

  task automatic idle_cycles(input int cnt);
    for (int k = 0; k < cnt; k++) begin
      start = 1'b0;
      @(negedge clk);
      check_all_zero("idle", k);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rand_regs();
    for (int r = 0; r < 8; r++) regs[r] = 8'($urandom_range(0, 255));
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    base_addr = 8'h00;
    for (int r = 0; r < 8; r++) regs[r] = 8'd0;
    @(posedge clk);
    @(posedge clk);
    #1;
    @(negedge clk);
    check_all_zero("reset", 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle_cycles(2);

    // Basic multiply: expected C = {19, 22, 43, 50}
    for (int r = 0; r < 8; r++) regs[r] = 8'(r + 1);
    run_op(8'h10, -1, 1'b0);
    // Back-to-back start in the first IDLE cycle
    rand_regs();
    run_op(8'($urandom_range(0, 255)), -1, 1'b0);
    idle_cycles(2);

    // Overflow: every c_ij = 512
    for (int r = 0; r < 8; r++) regs[r] = 8'd16;
    run_op(8'h00, -1, 1'b0);
    idle_cycles(1);

    // Address wrap
    rand_regs();
    run_op(8'hFE, -1, 1'b0);
    idle_cycles(1);

    // start pulses while busy and during DONE are dropped
    rand_regs();
    run_op(8'h20, -1, 1'b1);
    idle_cycles(2);

    // Reset during element 1 WRITE, then a fresh operation
    rand_regs();
    run_op(8'h30, 6, 1'b0);
    idle_cycles(1);
    rand_regs();
    run_op(8'h50, -1, 1'b0);
    idle_cycles(1);

    // Random operations
    for (int t = 0; t < 6; t++) begin
      rand_regs();
      run_op(8'($urandom_range(0, 255)), -1, 1'(t % 2));
      idle_cycles(t % 3);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
